// File: rtl/sfu_psum_feeder.sv
// Feeds partial-sum rows from the systolic array output FIFO to the SFU,
// grouping num_acc rows per output and running num_out groups per job.
module sfu_psum_feeder #(
  parameter int unsigned col     = 8,
  parameter int unsigned psum_bw = 16,
  parameter int unsigned cnt_bw  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [cnt_bw-1:0]        num_acc,
  input  logic [cnt_bw-1:0]        num_out,
  input  logic                     fifo_empty,
  input  logic [psum_bw*col-1:0]   fifo_rdata,
  output logic                     fifo_rd,
  output logic [psum_bw*col-1:0]   psum_o,
  output logic                     acc_o,
  output logic                     first_o,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned ProdW = 2 * cnt_bw;
  localparam int unsigned RowW  = psum_bw * col;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [cnt_bw-1:0] num_acc_q, num_acc_d;
  logic [cnt_bw-1:0] num_out_q, num_out_d;
  logic [cnt_bw-1:0] acc_cnt_q, acc_cnt_d;
  logic [cnt_bw-1:0] out_cnt_q, out_cnt_d;
  logic [ProdW-1:0]  rd_issued_q, rd_issued_d;
  logic [ProdW-1:0]  total_rows;
  logic              pend_q, pend_d;
  logic              acc_q, acc_d;
  logic              first_q, first_d;
  logic [RowW-1:0]   psum_q, psum_d;

  assign total_rows = {{cnt_bw{1'b0}}, num_acc_q} * {{cnt_bw{1'b0}}, num_out_q};

  always_comb begin
    state_d     = state_q;
    num_acc_d   = num_acc_q;
    num_out_d   = num_out_q;
    acc_cnt_d   = acc_cnt_q;
    out_cnt_d   = out_cnt_q;
    rd_issued_d = rd_issued_q;
    psum_d      = psum_q;
    acc_d       = 1'b0;
    first_d     = 1'b0;
    fifo_rd     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_acc_d   = num_acc;
          num_out_d   = num_out;
          rd_issued_d = '0;
          acc_cnt_d   = '0;
          out_cnt_d   = '0;
          state_d     = (num_acc == '0 || num_out == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        // Reset and abort gate the strobe so no read leaks out in their cycle.
        fifo_rd = reset && !abort && !fifo_empty && (rd_issued_q < total_rows);
        if (fifo_rd) begin
          rd_issued_d = rd_issued_q + 1'b1;
          if (rd_issued_d == total_rows) state_d = StDrain;
        end
      end
      StDrain: begin
        if (acc_q && out_cnt_q == num_out_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Row read last cycle: capture it and advance the grouping counters.
    if (pend_q) begin
      psum_d  = fifo_rdata;
      acc_d   = 1'b1;
      first_d = (acc_cnt_q == '0);
      if (acc_cnt_q == num_acc_q - 1'b1) begin
        acc_cnt_d = '0;
        out_cnt_d = out_cnt_q + 1'b1;
      end else begin
        acc_cnt_d = acc_cnt_q + 1'b1;
      end
    end
    pend_d = fifo_rd;

    if (abort) begin
      state_d     = StIdle;
      num_acc_d   = '0;
      num_out_d   = '0;
      acc_cnt_d   = '0;
      out_cnt_d   = '0;
      rd_issued_d = '0;
      psum_d      = '0;
      acc_d       = 1'b0;
      first_d     = 1'b0;
      pend_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      num_acc_q   <= '0;
      num_out_q   <= '0;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      rd_issued_q <= '0;
      pend_q      <= 1'b0;
      acc_q       <= 1'b0;
      first_q     <= 1'b0;
      psum_q      <= '0;
    end else begin
      state_q     <= state_d;
      num_acc_q   <= num_acc_d;
      num_out_q   <= num_out_d;
      acc_cnt_q   <= acc_cnt_d;
      out_cnt_q   <= out_cnt_d;
      rd_issued_q <= rd_issued_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      psum_q      <= psum_d;
    end
  end

  assign psum_o  = psum_q;
  assign acc_o   = acc_q;
  assign first_o = first_q;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);

endmodule

// File: tb/tb_sfu_psum_feeder.sv
// Randomised and directed bench for sfu_psum_feeder against a FIFO model and
// an expected-row queue derived from the grouping rules.
module tb_sfu_psum_feeder;

  localparam int Col = 8;
  localparam int Bw  = 16;
  localparam int Cw  = 8;
  localparam int W   = Col * Bw;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [Cw-1:0] num_acc = '0;
  logic [Cw-1:0] num_out = '0;
  logic          fifo_empty;
  logic [W-1:0]  fifo_rdata = '0;
  logic          fifo_rd;
  logic [W-1:0]  psum_o;
  logic          acc_o, first_o, busy, done;

  sfu_psum_feeder #(.col(Col), .psum_bw(Bw), .cnt_bw(Cw)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .num_acc    (num_acc),
    .num_out    (num_out),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .psum_o     (psum_o),
    .acc_o      (acc_o),
    .first_o    (first_o),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the read strobe.
  logic [W-1:0] mem [0:255];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] exp_rows[$];

  assign fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd) begin
      fifo_rdata <= mem[rd_ptr % 256];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  // Monitor
  int           cyc = 0;
  int           rd_cnt, acc_cnt, done_cnt, busy_cnt, viol, lat_err;
  logic [W-1:0] got_psum[$];
  logic         got_first[$];
  int           rd_cyc[$];
  logic         clr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clr) begin
      rd_cnt = 0; acc_cnt = 0; done_cnt = 0; busy_cnt = 0; viol = 0; lat_err = 0;
      got_psum.delete(); got_first.delete(); rd_cyc.delete();
    end else begin
      if (fifo_rd) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
        if (fifo_empty || !busy) viol++;
      end
      if (acc_o) begin
        acc_cnt++;
        got_psum.push_back(psum_o);
        got_first.push_back(first_o);
        if (rd_cyc.size() == 0) lat_err++;
        else if (cyc - rd_cyc.pop_front() != 2) lat_err++;
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    @(negedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic preload(input int n, input bit rnd);
    logic [W-1:0] row;
    for (int i = 0; i < n; i++) begin
      if (rnd) for (int l = 0; l < Col; l++) row[l*Bw +: Bw] = Bw'($urandom);
      else row = {Col{Bw'(i + 1)}};
      mem[wr_ptr % 256] = row;
      exp_rows.push_back(row);
      wr_ptr++;
    end
  endtask

  task automatic run_job(input int na, input int no, input bit rstall, input int stall_after,
                         input bit extra);
    int           total = na * no;
    int           guard = 0;
    bit           stalled = 1'b0;
    bit           xstart = 1'b0;
    int           exp_busy = total == 0 ? 1 : total + 3;
    logic [W-1:0] er, gr;
    logic         gf;
    clear_mon();
    num_acc = Cw'(na);
    num_out = Cw'(no);
    start = 1'b1;
    step();
    start = 1'b0;
    num_acc = Cw'($urandom);
    num_out = Cw'($urandom);
    while (done_cnt == 0 && guard < 400) begin
      if (rstall) stall = ($urandom_range(0, 3) == 0);
      if (stall_after > 0 && !stalled && rd_cnt == stall_after) begin
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        stalled = 1'b1;
        exp_busy += 3;
      end
      if (extra && !xstart && rd_cnt == 1) begin
        num_acc = 8'd1;
        num_out = 8'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        xstart = 1'b1;
      end
      step();
      guard++;
    end
    stall = 1'b0;
    step();
    step();
    check("timeout", W'(guard < 400), W'(1));
    check("rd_count", W'(rd_cnt), W'(total));
    check("acc_count", W'(acc_cnt), W'(total));
    check("done_pulses", W'(done_cnt), W'(1));
    check("busy_after", W'(busy), W'(0));
    check("rd_illegal", W'(viol), W'(0));
    check("latency", W'(lat_err), W'(0));
    if (!rstall) check("busy_cycles", W'(busy_cnt), W'(exp_busy));
    for (int i = 0; i < total; i++) begin
      er = exp_rows.pop_front();
      gr = (i < got_psum.size()) ? got_psum[i] : 'x;
      gf = (i < got_first.size()) ? got_first[i] : 1'bx;
      check($sformatf("row%0d", i), gr, er);
      check($sformatf("first%0d", i), W'(gf), W'((i % na) == 0));
    end
  endtask

  initial begin
    int g;
    reset = 1'b0;
    preload(1, 1'b0);
    step();
    step();
    check("rst_busy", W'(busy), W'(0));
    check("rst_acc", W'(acc_o), W'(0));
    check("rst_psum", psum_o, '0);
    check("rst_done", W'(done), W'(0));
    check("rst_rd", W'(fifo_rd), W'(0));
    flush = 1'b1; step(); flush = 1'b0;
    exp_rows.delete();
    reset = 1'b1;
    step();

    // Basic 3x2 job, then the same with a 3-cycle empty gap after read 2.
    preload(6, 1'b0);
    run_job(3, 2, 1'b0, 0, 1'b0);
    preload(6, 1'b0);
    run_job(3, 2, 1'b0, 2, 1'b0);

    // Zero-sized job goes straight to DONE.
    run_job(0, 5, 1'b0, 0, 1'b0);

    // Extra start mid-job is ignored.
    preload(4, 1'b1);
    run_job(2, 2, 1'b0, 0, 1'b1);

    // Reset mid-job, then a fresh job.
    preload(6, 1'b0);
    clear_mon();
    num_acc = 8'd3; num_out = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    g = 0;
    while (rd_cnt < 2 && g < 50) begin step(); g++; end
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rstmid_busy", W'(busy), W'(0));
    check("rstmid_acc", W'(acc_o), W'(0));
    check("rstmid_psum", psum_o, '0);
    repeat (5) step();
    check("rstmid_rd", W'(rd_cnt), W'(2));
    check("rstmid_done", W'(done_cnt), W'(0));
    flush = 1'b1; step(); flush = 1'b0;
    exp_rows.delete();
    preload(2, 1'b1);
    run_job(2, 1, 1'b0, 0, 1'b0);

    // Abort in DRAIN drops the pending row and suppresses done.
    preload(2, 1'b0);
    clear_mon();
    num_acc = 8'd2; num_out = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    g = 0;
    while (rd_cnt < 2 && g < 50) begin step(); g++; end
    check("abort_in_drain_busy", W'(busy), W'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", W'(busy), W'(0));
    check("abort_acc", W'(acc_o), W'(0));
    check("abort_first", W'(first_o), W'(0));
    check("abort_psum", psum_o, '0);
    repeat (4) step();
    check("abort_rows", W'(acc_cnt), W'(1));
    check("abort_done", W'(done_cnt), W'(0));
    exp_rows.delete();

    // Random jobs with random FIFO stalls.
    for (int j = 0; j < 12; j++) begin
      int na = $urandom_range(1, 4);
      int no = $urandom_range(1, 4);
      preload(na * no, 1'b1);
      run_job(na, no, 1'b1, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
